// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blank pattern, hex glyph table
// and an index-width helper.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs for nibbles 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble + decimal point to active-low {dp,g,f,e,d,c,b,a}.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] segments
);

    assign segments = {~dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered display data.
// Define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    pending,
    output logic                    frame_done,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IW = clog2(NUM_DIGITS);
    localparam int CW = clog2(SCAN_DIV);
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         div_cnt;
    logic [IW-1:0]         digit_idx;
    logic [DW-1:0]         sh_data, act_data, nxt_data;
    logic [NUM_DIGITS-1:0] sh_dp, act_dp, nxt_dp;
    logic [NUM_DIGITS-1:0] sh_en, act_en, nxt_en;
    logic                  div_last, idx_last, frame_end, xfer;
    logic                  blank, hide;
    logic [7:0]            dec_seg;

    assign div_last  = (div_cnt == CW'(SCAN_DIV - 1));
    assign idx_last  = (digit_idx == IW'(NUM_DIGITS - 1));
    assign frame_end = div_last && idx_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (div_last) begin
            div_cnt   <= '0;
            digit_idx <= idx_last ? '0 : digit_idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // A load landing on the frame-end edge bypasses the shadow entirely.
    always_comb begin
        xfer     = 1'b0;
        nxt_data = sh_data;
        nxt_dp   = sh_dp;
        nxt_en   = sh_en;
        if (frame_end && load) begin
            xfer     = 1'b1;
            nxt_data = data_in;
            nxt_dp   = dp_in;
            nxt_en   = digit_en;
        end else if (frame_end && pending) begin
            xfer = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_en    <= '0;
            act_data <= '0;
            act_dp   <= '0;
            act_en   <= '0;
            pending  <= 1'b0;
        end else begin
            if (load && !frame_end) begin
                sh_data <= data_in;
                sh_dp   <= dp_in;
                sh_en   <= digit_en;
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
            if (xfer) begin
                act_data <= nxt_data;
                act_dp   <= nxt_dp;
                act_en   <= nxt_en;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] sup_mask;

    // Walk down from the top digit; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] d,
                                                      input logic [NUM_DIGITS-1:0] p);
        logic lead;
        lz_mask = '0;
        lead    = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (d[4*i +: 4] != 4'h0 || p[i]) lead = 1'b0;
            lz_mask[i] = lead;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sup_mask <= '0;
        else if (xfer) sup_mask <= lz_mask(nxt_data, nxt_dp);
    end

    assign hide = !act_en[digit_idx] || sup_mask[digit_idx];
`else
    assign hide = !act_en[digit_idx];
`endif

    assign blank = int'(div_cnt) < BLANK_CYCLES;

    seg7_hex_decoder u_dec (
        .nibble   (act_data[{digit_idx, 2'b00} +: 4]),
        .dp       (act_dp[digit_idx]),
        .segments (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            segments   <= SEG_OFF;
            an         <= '1;
        end else begin
            frame_done <= frame_end;
            if (blank || hide) begin
                segments <= SEG_OFF;
                an       <= '1;
            end else begin
                segments <= dec_seg;
                an       <= ~(NUM_DIGITS'(1) << digit_idx);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: cycle scoreboard plus per-vector digit captures.
module tb_seg7_scan_driver;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        load = 1'b0;
    logic        pending, frame_done;
    logic [7:0]  segments;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .digit_en(digit_en), .load(load), .pending(pending),
        .frame_done(frame_done), .segments(segments), .an(an)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] DEC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       pend;
        logic       fd;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    logic [2:0]  m_div;
    logic [1:0]  m_idx;
    logic [15:0] m_data, s_data;
    logic [3:0]  m_dp, m_en, s_dp, s_en, m_sup;
    logic        m_pend, m_fe;

    function automatic logic [3:0] lz_ref(input logic [15:0] d, input logic [3:0] p);
        int i;
        logic [3:0] m;
        i = 3;
        m = '0;
        while (i > 0 && d[i*4 +: 4] == 4'h0 && !p[i]) begin
            m[i] = 1'b1;
            i--;
        end
        return m;
    endfunction

    always_comb begin
        m_fe   = (m_div == 3'd7) && (m_idx == 2'd3);
        m_e.fd = m_fe;
        m_e.an = 4'hF;
        m_e.seg = 8'hFF;
        if (m_div >= 3'd2 && m_en[m_idx] && !m_sup[m_idx]) begin
            m_e.an  = ~(4'b0001 << m_idx);
            m_e.seg = {~m_dp[m_idx], DEC[m_data[m_idx*4 +: 4]]};
        end
        if (load)      m_e.pend = !m_fe;
        else if (m_fe) m_e.pend = 1'b0;
        else           m_e.pend = m_pend;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div <= '0; m_idx <= '0; m_pend <= 1'b0;
            m_data <= '0; m_dp <= '0; m_en <= '0; m_sup <= '0;
            s_data <= '0; s_dp <= '0; s_en <= '0;
        end else begin
            q.push_back(m_e);
            m_pend <= m_e.pend;
            m_div  <= m_div + 3'd1;
            if (m_div == 3'd7) m_idx <= m_idx + 2'd1;
            if (load && !m_fe) begin
                s_data <= data_in; s_dp <= dp_in; s_en <= digit_en;
            end
            if (load && m_fe) begin
                m_data <= data_in; m_dp <= dp_in; m_en <= digit_en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                m_sup <= lz_ref(data_in, dp_in);
`endif
            end else if (m_fe && m_pend) begin
                m_data <= s_data; m_dp <= s_dp; m_en <= s_en;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                m_sup <= lz_ref(s_data, s_dp);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && q.size() != 0) begin
            chk("cycle", {18'd0, an, segments, pending, frame_done}, {18'd0, q[0]});
            q.delete(0);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      en;
        logic [3:0]      seen;
        logic [3:0][7:0] seg;
    } vec_t;

    vec_t vecs[$];

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done expected pulse within 100 cycles");
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        @(negedge clk);
        data_in = d; dp_in = p; digit_en = e; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Starts at the negedge carrying frame_done; observes the next full frame.
    task automatic capture(input vec_t v);
        logic [3:0][7:0] got;
        logic [3:0] seen, a0, a2;
        logic an_bad, ok, fd;
        got = '0; seen = '0; an_bad = 1'b0; a0 = '0; a2 = '0; fd = 1'b0;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            if (j == 0) a0 = an;
            if (j == 2) a2 = an;
            if (j == 31) fd = frame_done;
            ok = (an == 4'hF);
            for (int i = 0; i < N; i++) begin
                if (an == ~(4'b0001 << i)) begin
                    seen[i] = 1'b1;
                    got[i]  = segments;
                    if (v.seen[i]) ok = 1'b1;
                end
            end
            if (!ok) an_bad = 1'b1;
        end
        chk("seen_mask", {28'd0, seen}, {28'd0, v.seen});
        for (int i = 0; i < N; i++)
            if (v.seen[i]) chk($sformatf("seg_d%0d", i), {24'd0, got[i]}, {24'd0, v.seg[i]});
        chk("blank_slot0", {28'd0, a0}, 32'hF);
        chk("first_lit", {28'd0, a2}, v.seen[0] ? 32'hE : 32'hF);
        chk("frame_period", {31'd0, fd}, 32'd1);
        chk("an_legal", {31'd0, an_bad}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        wait_frame();
        repeat (5) @(negedge clk);
        do_load(~v.data, ~v.dp, 4'hF);
        do_load(v.data, v.dp, v.en);
        chk("pending_set", {31'd0, pending}, 32'd1);
        wait_frame();
        chk("pending_clr", {31'd0, pending}, 32'd0);
        capture(v);
    endtask

    initial begin
        vec_t v;
        v = '{16'h0001, 4'b0000, 4'hF, 4'hF, {8'hC0, 8'hC0, 8'hC0, 8'hF9}};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        v.seen = 4'b0001;
`endif
        vecs.push_back(v);
        vecs.push_back('{16'hA808, 4'b0010, 4'hF, 4'hF, {8'h88, 8'h80, 8'h40, 8'h80}});
        vecs.push_back('{16'hF5C7, 4'b1001, 4'hF, 4'hF, {8'h0E, 8'h92, 8'hC6, 8'h78}});
        vecs.push_back('{16'h9EB3, 4'b0000, 4'b0101, 4'b0101, {8'hFF, 8'h86, 8'hFF, 8'hB0}});
        vecs.push_back('{16'h6D24, 4'b0100, 4'hF, 4'hF, {8'h82, 8'h21, 8'hA4, 8'h99}});
        v = '{16'h0050, 4'b0000, 4'hF, 4'hF, {8'hC0, 8'hC0, 8'h92, 8'hC0}};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        v.seen = 4'b0011;
`endif
        vecs.push_back(v);

        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {24'd0, segments}, 32'hFF);
        chk("rst_pend", {31'd0, pending}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Load on the frame-end edge goes straight to the display.
        wait_frame();
        repeat (31) @(negedge clk);
        data_in = 16'h3210; dp_in = 4'b0000; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("fe_align", {31'd0, frame_done}, 32'd1);
        chk("fe_pending", {31'd0, pending}, 32'd0);
        capture('{16'h3210, 4'b0000, 4'hF, 4'hF, {8'hB0, 8'hA4, 8'hF9, 8'hC0}});

        // Asynchronous reset in the middle of a dwell with a load pending.
        repeat (11) @(negedge clk);
        do_load(16'h7777, 4'hF, 4'hF);
        chk("pre_rst_pend", {31'd0, pending}, 32'd1);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_seg", {24'd0, segments}, 32'hFF);
        chk("async_pend", {31'd0, pending}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_dark", {28'd0, an}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
